// File: rtl/fir_capture_pkg.sv
//------------------------------------------------------------------------------
// Module : fir_capture_pkg
// Brief  : Shared FSM state encoding and datapath widths for the FIR capture path.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fir_capture_pkg;

    localparam int FIR_DATA_W = 16;
    localparam int FIR_ADDR_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

endpackage

`default_nettype wire

// File: rtl/fir_capture_buffer_ram.sv
//------------------------------------------------------------------------------
// Module : capture_ram
// Brief  : Simple dual-port sample store, one write port, one registered read port.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module capture_ram
    import fir_capture_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int ADDR_W = FIR_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // No reset: contents survive rst_n and map cleanly onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/fir_capture_buffer.sv
//------------------------------------------------------------------------------
// Module : fir_capture_buffer
// Brief  : Skips a fixed number of valid filter samples, stores the next CAP_LEN,
//          then offers 1-cycle readback. CAPTURE_STATS_EN adds min_val/max_val.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fir_capture_buffer
    import fir_capture_pkg::*;
#(
    parameter int DATA_W   = FIR_DATA_W,
    parameter int ADDR_W   = FIR_ADDR_W,
    parameter int CAP_LEN  = 8000,
    parameter int SKIP_LEN = 62
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] y_in,
    input  logic                     y_valid,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W:0]          count
`ifdef CAPTURE_STATS_EN
    ,
    output logic signed [DATA_W-1:0] min_val,
    output logic signed [DATA_W-1:0] max_val
`endif
);

    localparam int C_SKIP_LAST = (SKIP_LEN > 0) ? SKIP_LEN - 1 : 0;
    localparam int C_CAP_LAST  = CAP_LEN - 1;
    localparam logic [ADDR_W:0] C_SKIP_LAST_W = C_SKIP_LAST[ADDR_W:0];
    localparam logic [ADDR_W:0] C_CAP_LAST_W  = C_CAP_LAST[ADDR_W:0];
    localparam cap_state_e C_ARM_STATE = (SKIP_LEN == 0) ? ST_CAPTURE : ST_SKIP;

    cap_state_e         state_q, state_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [ADDR_W:0]    skip_cnt_q, skip_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_zero_q, rd_zero_d;
    logic               wr_en;
    logic               rd_accept;
    logic [DATA_W-1:0]  ram_rdata;

`ifdef CAPTURE_STATS_EN
    logic signed [DATA_W-1:0] min_q, min_d;
    logic signed [DATA_W-1:0] max_q, max_d;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        skip_cnt_d = skip_cnt_q;
        wr_en      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = C_ARM_STATE;
                    count_d    = '0;
                    skip_cnt_d = '0;
                end
            end
            ST_SKIP: begin
                if (y_valid) begin
                    skip_cnt_d = skip_cnt_q + 1'b1;
                    if (skip_cnt_q == C_SKIP_LAST_W) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (y_valid) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                    // Leaving on the last write keeps the address inside 0..CAP_LEN-1.
                    if (count_q == C_CAP_LAST_W) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SKIP) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);

        // Reads are served from the pre-edge state, so start+rd_en in DONE still reads.
        rd_accept  = rd_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        rd_valid_d = rd_accept;
        rd_zero_d  = rd_accept ? ({1'b0, rd_addr} >= count_q) : rd_zero_q;
    end

`ifdef CAPTURE_STATS_EN
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (wr_en) begin
            if (count_q == '0) begin
                min_d = y_in;
                max_d = y_in;
            end else begin
                if (y_in < min_q) min_d = y_in;
                if (y_in > max_q) max_d = y_in;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            skip_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b1;
`ifdef CAPTURE_STATS_EN
            min_q      <= '0;
            max_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            skip_cnt_q <= skip_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_zero_q  <= rd_zero_d;
`ifdef CAPTURE_STATS_EN
            min_q      <= min_d;
            max_q      <= max_d;
`endif
        end
    end

    capture_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (count_q[ADDR_W-1:0]),
        .wdata (y_in),
        .re    (rd_accept),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // The RAM has no reset, so a flag forces zero after reset and for out-of-range reads.
    assign rd_data  = rd_zero_q ? '0 : ram_rdata;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
`ifdef CAPTURE_STATS_EN
    assign min_val  = min_q;
    assign max_val  = max_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fir_capture_buffer.sv
//------------------------------------------------------------------------------
// Module : tb_fir_capture_buffer
// Brief  : Directed self-checking bench for fir_capture_buffer (default parameters).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fir_capture_buffer;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [15:0] y_in;
    logic               y_valid;
    logic               rd_en;
    logic [12:0]        rd_addr;
    logic [15:0]        rd_data;
    logic               rd_valid;
    logic               busy;
    logic               done;
    logic [13:0]        count;
`ifdef CAPTURE_STATS_EN
    logic signed [15:0] min_val;
    logic signed [15:0] max_val;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fir_capture_buffer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .y_in     (y_in),
        .y_valid  (y_valid),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .done     (done),
        .count    (count)
`ifdef CAPTURE_STATS_EN
        ,
        .min_val  (min_val),
        .max_val  (max_val)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] v);
        y_in    = v;
        y_valid = 1'b1;
        tick();
        y_valid = 1'b0;
    endtask

    task automatic rd(input int a);
        rd_en   = 1'b1;
        rd_addr = 13'(a);
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got %0b want 0", done); end
        n_cmp++; if (count !== 14'd0)   begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 16'h0) begin n_bad++; $display("FAIL reset_rd_data got %h want 0000", rd_data); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        pulse_start();
        n_cmp++; if (busy !== 1'b1)   begin n_bad++; $display("FAIL basic_busy got %0b want 1", busy); end
        n_cmp++; if (count !== 14'd0) begin n_bad++; $display("FAIL basic_count0 got %0d want 0", count); end
        for (int i = 0; i < 8062; i++) begin
            feed(16'(i));
            if (i == 8060) begin
                n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_early_done got %0b want 0", done); end
            end
        end
        n_cmp++; if (done !== 1'b1)      begin n_bad++; $display("FAIL basic_done got %0b want 1", done); end
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL basic_busy_end got %0b want 0", busy); end
        n_cmp++; if (count !== 14'd8000) begin n_bad++; $display("FAIL basic_count got %0d want 8000", count); end
        feed(16'hABCD);
        n_cmp++; if (count !== 14'd8000) begin n_bad++; $display("FAIL basic_done_ignore got %0d want 8000", count); end
        rd(0);
        n_cmp++; if (rd_valid !== 1'b1)  begin n_bad++; $display("FAIL basic_rv0 got %0b want 1", rd_valid); end
        n_cmp++; if (rd_data !== 16'd62) begin n_bad++; $display("FAIL basic_rd0 got %0d want 62", rd_data); end
        rd(7999);
        n_cmp++; if (rd_data !== 16'd8061) begin n_bad++; $display("FAIL basic_rd7999 got %0d want 8061", rd_data); end
    endtask

    task automatic test_misc();
        rd(8000);
        n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL misc_oor_valid got %0b want 1", rd_valid); end
        n_cmp++; if (rd_data !== 16'h0) begin n_bad++; $display("FAIL misc_oor_data got %h want 0000", rd_data); end
        // start and rd_en together in DONE
        rd_en = 1'b1; rd_addr = 13'd0; start = 1'b1;
        tick();
        rd_en = 1'b0; start = 1'b0;
        n_cmp++; if (rd_valid !== 1'b1)  begin n_bad++; $display("FAIL misc_sr_valid got %0b want 1", rd_valid); end
        n_cmp++; if (rd_data !== 16'd62) begin n_bad++; $display("FAIL misc_sr_data got %0d want 62", rd_data); end
        n_cmp++; if (busy !== 1'b1)      begin n_bad++; $display("FAIL misc_sr_busy got %0b want 1", busy); end
        n_cmp++; if (count !== 14'd0)    begin n_bad++; $display("FAIL misc_sr_count got %0d want 0", count); end
        repeat (62) feed(16'h1111);
        for (int i = 0; i < 10; i++) feed(16'(1000 + i));
        n_cmp++; if (count !== 14'd10) begin n_bad++; $display("FAIL misc_count10 got %0d want 10", count); end
        pulse_start();
        feed(16'd1010);
        n_cmp++; if (count !== 14'd11) begin n_bad++; $display("FAIL misc_start_ignored got %0d want 11", count); end
        n_cmp++; if (busy !== 1'b1)    begin n_bad++; $display("FAIL misc_busy_kept got %0b want 1", busy); end
        rd(1);
        n_cmp++; if (rd_valid !== 1'b0)  begin n_bad++; $display("FAIL misc_busy_rv got %0b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 16'd62) begin n_bad++; $display("FAIL misc_busy_hold got %0d want 62", rd_data); end
        for (int i = 11; i < 8000; i++) feed(16'(1000 + i));
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL misc_done got %0b want 1", done); end
        rd(10);
        n_cmp++; if (rd_data !== 16'd1010) begin n_bad++; $display("FAIL misc_rd10 got %0d want 1010", rd_data); end
    endtask

    task automatic test_gaps();
        pulse_start();
        for (int k = 0; k < 124; k++) begin
            if (k % 2 == 0) feed(16'h2222);
            else begin y_in = 16'hDEAD; y_valid = 1'b0; tick(); end
        end
        n_cmp++; if (count !== 14'd0) begin n_bad++; $display("FAIL gaps_skip_count got %0d want 0", count); end
        for (int i = 0; i < 8000; i++) begin
            feed(16'(3000 + i));
            y_in = 16'hDEAD; y_valid = 1'b0;
            tick();
            if (i == 4) begin
                n_cmp++; if (count !== 14'd5) begin n_bad++; $display("FAIL gaps_count5 got %0d want 5", count); end
            end
        end
        n_cmp++; if (count !== 14'd8000) begin n_bad++; $display("FAIL gaps_count got %0d want 8000", count); end
        n_cmp++; if (done !== 1'b1)      begin n_bad++; $display("FAIL gaps_done got %0b want 1", done); end
        rd(0);
        n_cmp++; if (rd_data !== 16'd3000)  begin n_bad++; $display("FAIL gaps_rd0 got %0d want 3000", rd_data); end
        rd(5);
        n_cmp++; if (rd_data !== 16'd3005)  begin n_bad++; $display("FAIL gaps_rd5 got %0d want 3005", rd_data); end
        rd(7999);
        n_cmp++; if (rd_data !== 16'd10999) begin n_bad++; $display("FAIL gaps_rd7999 got %0d want 10999", rd_data); end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        repeat (62) feed(16'h0);
        for (int i = 0; i < 100; i++) feed(16'(i));
        n_cmp++; if (count !== 14'd100) begin n_bad++; $display("FAIL rmid_pre got %0d want 100", count); end
        rst_n = 1'b0;
        #2;
        n_cmp++; if (count !== 14'd0) begin n_bad++; $display("FAIL rmid_count got %0d want 0", count); end
        n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL rmid_busy got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0)   begin n_bad++; $display("FAIL rmid_done got %0b want 0", done); end
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        repeat (62) feed(16'h0);
        for (int i = 0; i < 8000; i++) feed(16'(20000 + i));
        n_cmp++; if (count !== 14'd8000) begin n_bad++; $display("FAIL rmid_full got %0d want 8000", count); end
        n_cmp++; if (done !== 1'b1)      begin n_bad++; $display("FAIL rmid_done2 got %0b want 1", done); end
        rd(7999);
        n_cmp++; if (rd_data !== 16'd27999) begin n_bad++; $display("FAIL rmid_rd got %0d want 27999", rd_data); end
    endtask

    task automatic test_signed();
        pulse_start();
        repeat (62) feed(16'h0);
        feed(16'h8000);
        feed(16'h7FFF);
        repeat (7998) feed(16'h0);
        rd(0);
        n_cmp++; if (rd_data !== 16'h8000) begin n_bad++; $display("FAIL signed_neg got %h want 8000", rd_data); end
        rd(1);
        n_cmp++; if (rd_data !== 16'h7FFF) begin n_bad++; $display("FAIL signed_pos got %h want 7fff", rd_data); end
    endtask

`ifdef CAPTURE_STATS_EN
    task automatic test_stats();
        pulse_start();
        repeat (62) feed(16'h0);
        feed(16'hFFFB);
        feed(16'h0003);
        feed(16'h7FFF);
        n_cmp++; if (min_val !== 16'hFFFB) begin n_bad++; $display("FAIL stats_min got %h want fffb", min_val); end
        n_cmp++; if (max_val !== 16'h7FFF) begin n_bad++; $display("FAIL stats_max got %h want 7fff", max_val); end
    endtask
`endif

    initial begin
        start = 1'b0; y_in = '0; y_valid = 1'b0; rd_en = 1'b0; rd_addr = '0; rst_n = 1'b1;
        #3;
        test_reset();
        test_basic();
        test_misc();
        test_gaps();
        test_reset_mid();
        test_signed();
`ifdef CAPTURE_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fir_capture_buffer.md
FIR_CAPTURE_BUFFER -- requirements
Module: fir_capture_buffer

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, sample width; ADDR_W, default 13, buffer address width; CAP_LEN, default 8000, samples stored per capture; SKIP_LEN, default 62, valid samples discarded before storing.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be (name direction width meaning):
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  start  in  1  one-cycle pulse that arms a capture
  y_in  in  DATA_W  signed filter-chain output sample
  y_valid  in  1  y_in qualifier
  rd_en  in  1  readback request
  rd_addr  in  ADDR_W  readback address
  rd_data  out  DATA_W  readback sample
  rd_valid  out  1  rd_data qualifier
  busy  out  1  high in SKIP or CAPTURE
  done  out  1  high in DONE
  count  out  ADDR_W+1  samples stored in the current or last capture

Function
REQ-004 FSM states SHALL be IDLE, SKIP, CAPTURE and DONE.
REQ-005 Transitions SHALL be:
  - IDLE->SKIP on start; SKIP_LEN==0 goes IDLE->CAPTURE.
  - SKIP->CAPTURE after SKIP_LEN valid samples are discarded.
  - CAPTURE->DONE on the cycle the CAP_LEN-th sample is written.
  - DONE->SKIP on start.
REQ-006 start SHALL clear count and the skip counter to 0 on the next edge.
REQ-007 start asserted in SKIP or CAPTURE SHALL be ignored.
REQ-008 In SKIP, only cycles with y_valid=1 SHALL advance the skip counter; nothing is written.
REQ-009 In CAPTURE, each cycle with y_valid=1 SHALL write y_in to address count and increment count; y_valid=0 SHALL leave both unchanged.
REQ-010 Samples SHALL be stored unmodified: no truncation, no sign change.
REQ-011 The write address SHALL never exceed CAP_LEN-1 and SHALL never wrap; y_valid in DONE or IDLE SHALL be ignored.
REQ-012 Readback SHALL have 1-cycle latency: rd_en=1 in DONE or IDLE gives rd_valid=1 and rd_data=mem[rd_addr] on the next cycle.
REQ-013 rd_en while busy SHALL be ignored: rd_valid=0 and rd_data holds its value.
REQ-014 rd_addr>=count SHALL return rd_valid=1 with rd_data=0.
REQ-015 start and rd_en in the same DONE cycle SHALL complete the read and also begin SKIP.

Reset
REQ-016 rst_n=0 SHALL force state IDLE and set busy, done, rd_valid, rd_data, count and the skip counter to 0, mid-capture included.
REQ-017 Reset SHALL NOT clear buffer contents.
REQ-018 The first start after reset release SHALL behave as from IDLE.

Configuration
REQ-019 With CAPTURE_STATS_EN defined, the block SHALL add outputs min_val and max_val (DATA_W, signed):
  - both track stored samples only;
  - both reset to 0;
  - the first stored sample of a capture loads both.
REQ-020 With CAPTURE_STATS_EN undefined, those ports and that logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-021 Package fir_capture_pkg SHALL hold the FSM state enum plus DATA_W and ADDR_W defaults shared with the filter blocks.
REQ-022 Storage SHALL be a sub-module capture_ram: simple dual-port, 1 write port, 1 synchronous read port, no reset, 2**ADDR_W x DATA_W.

Verification
REQ-023 The bench SHALL cover these scenarios:
  - Basic capture: SKIP_LEN=62, CAP_LEN=8000, start, ramp 0..8061 with y_valid=1 each cycle -> done after 8062 valid samples, count=8000, rd_addr=0 reads 62, rd_addr=7999 reads 8061.
  - Gaps: y_valid toggles 1/0 -> count advances only on valid cycles, and stored data is contiguous.
  - Misc: start during CAPTURE ignored; rd_en while busy gives rd_valid=0; rd_addr=8000 after done reads 0.
  - Reset: rst_n low at count=100 -> IDLE, count=0, done=0; next start captures a full 8000.
  - Signed: samples 0x8000 and 0x7FFF stored and read back exactly.
  - Stats: with CAPTURE_STATS_EN, samples {-5, 3, 0x7FFF} -> min_val=-5, max_val=0x7FFF.
